// File: rtl/rwq_pkg.sv
// ----------------------------------------------------------------------------
// rwq_pkg
// Shared constants and types for the register write-back queue.
//   RWQ_ADDR_W  : default register index width
//   RWQ_DATA_W  : default register data width
//   rwq_entry_t : one queue slot {valid, reg index, data} at the default widths
// ----------------------------------------------------------------------------
package rwq_pkg;

  localparam int RWQ_ADDR_W = 5;
  localparam int RWQ_DATA_W = 32;

  typedef struct packed {
    logic                  valid;
    logic [RWQ_ADDR_W-1:0] idx;
    logic [RWQ_DATA_W-1:0] data;
  } rwq_entry_t;

endpackage

// File: rtl/rwq_fwd_match.sv
// ----------------------------------------------------------------------------
// rwq_fwd_match
// Youngest-match priority search over the queue storage for one lookup port.
// Ports:
//   entry_valid / entry_reg / entry_data : queue storage, one slot per entry
//   tail_ptr   : next write slot; tail_ptr-1 is the youngest entry
//   lookup_reg : register index to search for (index 0 never matches)
//   fwd_hit    : some valid entry holds lookup_reg
//   fwd_data   : data of the youngest matching entry, 0 on a miss
// ----------------------------------------------------------------------------
module rwq_fwd_match
  import rwq_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = RWQ_ADDR_W,
  parameter int DATA_W = RWQ_DATA_W,
  parameter int PTR_W  = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0]  entry_valid,
  input  logic [ADDR_W-1:0] entry_reg  [DEPTH],
  input  logic [DATA_W-1:0] entry_data [DEPTH],
  input  logic [PTR_W-1:0]  tail_ptr,
  input  logic [ADDR_W-1:0] lookup_reg,
  output logic              fwd_hit,
  output logic [DATA_W-1:0] fwd_data
);

  logic [PTR_W-1:0] idx;

  // Walk from oldest (tail-DEPTH == tail) to youngest (tail-1); a later
  // match overwrites an earlier one, so the youngest entry wins.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    idx      = '0;
    for (int k = DEPTH; k >= 1; k--) begin
      idx = tail_ptr - PTR_W'(k);
      if ((lookup_reg != '0) && entry_valid[idx] && (entry_reg[idx] == lookup_reg)) begin
        fwd_hit  = 1'b1;
        fwd_data = entry_data[idx];
      end
    end
  end

endmodule

// File: rtl/reg_writeback_queue.sv
// ----------------------------------------------------------------------------
// reg_writeback_queue
// In-order buffer between execution units and the register file write port,
// with an optional forwarding lookup onto the pending entries.
// Build option: define RWQ_FORWARD_EN to build the forwarding comparators;
// otherwise fwd_hit*/fwd_data* are tied to 0 and the lookups are ignored.
// Ports:
//   clk, rst_n                    : clock, async active-low reset
//   in_valid/in_ready/in_reg/in_data : producer handshake (reg 0 is dropped)
//   rf_busy                       : stalls the drain this cycle
//   write_reg/write_data/write_enable : head entry onto the register file
//   lookup_reg1/2, fwd_hit1/2, fwd_data1/2 : forwarding lookups
//   count                         : occupied entries
// ----------------------------------------------------------------------------
module reg_writeback_queue
  import rwq_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = RWQ_ADDR_W,
  parameter int DATA_W = RWQ_DATA_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ADDR_W-1:0]        in_reg,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     rf_busy,
  output logic [ADDR_W-1:0]        write_reg,
  output logic [DATA_W-1:0]        write_data,
  output logic                     write_enable,
  input  logic [ADDR_W-1:0]        lookup_reg1,
  input  logic [ADDR_W-1:0]        lookup_reg2,
  output logic                     fwd_hit1,
  output logic                     fwd_hit2,
  output logic [DATA_W-1:0]        fwd_data1,
  output logic [DATA_W-1:0]        fwd_data2,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [ADDR_W-1:0] reg_q  [DEPTH];
  logic [ADDR_W-1:0] reg_d  [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DATA_W-1:0] data_d [DEPTH];

  logic not_empty, push, pop;

  assign not_empty    = (count_q != '0);
  // Full is decided before any pop this cycle: no pass-through when full.
  assign in_ready     = (count_q != CNT_W'(DEPTH));
  // Register index 0 completes the handshake but is never stored.
  assign push         = in_valid && in_ready && (in_reg != '0);
  assign write_enable = not_empty && !rf_busy;
  assign pop          = write_enable;

  assign write_reg  = not_empty ? reg_q[head_q]  : '0;
  assign write_data = not_empty ? data_q[head_q] : '0;
  assign count      = count_q;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    valid_d = valid_q;
    reg_d   = reg_q;
    data_d  = data_q;
    if (push) begin
      valid_d[tail_q] = 1'b1;
      reg_d[tail_q]   = in_reg;
      data_d[tail_q]  = in_data;
      tail_d          = tail_q + 1'b1;
    end
    if (pop) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        reg_q[i]  <= '0;
        data_q[i] <= '0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      valid_q <= valid_d;
      reg_q   <= reg_d;
      data_q  <= data_d;
    end
  end

`ifdef RWQ_FORWARD_EN
  rwq_fwd_match #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .PTR_W(PTR_W)) u_fwd1 (
    .entry_valid (valid_q),
    .entry_reg   (reg_q),
    .entry_data  (data_q),
    .tail_ptr    (tail_q),
    .lookup_reg  (lookup_reg1),
    .fwd_hit     (fwd_hit1),
    .fwd_data    (fwd_data1)
  );

  rwq_fwd_match #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .PTR_W(PTR_W)) u_fwd2 (
    .entry_valid (valid_q),
    .entry_reg   (reg_q),
    .entry_data  (data_q),
    .tail_ptr    (tail_q),
    .lookup_reg  (lookup_reg2),
    .fwd_hit     (fwd_hit2),
    .fwd_data    (fwd_data2)
  );
`else
  // Without forwarding the lookups and per-slot valid bits have no reader.
  logic unused_fwd;
  assign unused_fwd = ^{lookup_reg1, lookup_reg2, valid_q};
  assign fwd_hit1   = 1'b0;
  assign fwd_hit2   = 1'b0;
  assign fwd_data1  = '0;
  assign fwd_data2  = '0;
`endif

endmodule

// File: tb/tb_reg_writeback_queue.sv
// ----------------------------------------------------------------------------
// tb_reg_writeback_queue
// Directed bench for reg_writeback_queue (DEPTH=4, ADDR_W=5, DATA_W=32).
// Forwarding expectations follow RWQ_FORWARD_EN: when it is not defined the
// forwarding outputs are expected to read 0.
// ----------------------------------------------------------------------------
module tb_reg_writeback_queue;

`ifdef RWQ_FORWARD_EN
  localparam bit FWD_EN = 1'b1;
`else
  localparam bit FWD_EN = 1'b0;
`endif

  typedef struct {
    logic        in_valid;
    logic [4:0]  in_reg;
    logic [31:0] in_data;
    logic        rf_busy;
    logic [4:0]  lk1;
    logic [4:0]  lk2;
    logic        exp_ready;
    logic        exp_we;
    logic [4:0]  exp_wr;
    logic [31:0] exp_wd;
    logic [2:0]  exp_cnt;
    logic        exp_hit1;
    logic [31:0] exp_fd1;
    logic        exp_hit2;
    logic [31:0] exp_fd2;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_reg;
  logic [31:0] in_data;
  logic        rf_busy;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic        write_enable;
  logic [4:0]  lookup_reg1;
  logic [4:0]  lookup_reg2;
  logic        fwd_hit1;
  logic        fwd_hit2;
  logic [31:0] fwd_data1;
  logic [31:0] fwd_data2;
  logic [2:0]  count;

  int compare_count  = 0;
  int mismatch_count = 0;

  vec_t vecs [15];

  reg_writeback_queue #(.DEPTH(4), .ADDR_W(5), .DATA_W(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_reg       (in_reg),
    .in_data      (in_data),
    .rf_busy      (rf_busy),
    .write_reg    (write_reg),
    .write_data   (write_data),
    .write_enable (write_enable),
    .lookup_reg1  (lookup_reg1),
    .lookup_reg2  (lookup_reg2),
    .fwd_hit1     (fwd_hit1),
    .fwd_hit2     (fwd_hit2),
    .fwd_data1    (fwd_data1),
    .fwd_data2    (fwd_data2),
    .count        (count)
  );

  always #5 clk = ~clk;

  // Builds one record; forwarding expectations are masked when forwarding is not built.
  function automatic vec_t mkv(
    input logic v, input logic [4:0] r, input logic [31:0] d, input logic busy,
    input logic [4:0] l1, input logic [4:0] l2,
    input logic rdy, input logic we, input logic [4:0] wr, input logic [31:0] wd,
    input logic [2:0] cnt, input logic h1, input logic [31:0] d1,
    input logic h2, input logic [31:0] d2);
    vec_t t;
    t.in_valid = v;  t.in_reg = r;  t.in_data = d;  t.rf_busy = busy;
    t.lk1 = l1;  t.lk2 = l2;
    t.exp_ready = rdy;  t.exp_we = we;  t.exp_wr = wr;  t.exp_wd = wd;  t.exp_cnt = cnt;
    t.exp_hit1 = h1 & FWD_EN;  t.exp_fd1 = FWD_EN ? d1 : 32'h0;
    t.exp_hit2 = h2 & FWD_EN;  t.exp_fd2 = FWD_EN ? d2 : 32'h0;
    return t;
  endfunction

  task automatic checkField(input string name, input int tag, input logic [31:0] act, input logic [31:0] exp);
    compare_count++;
    if (act !== exp) begin
      mismatch_count++;
      $display("[TB] FAIL %s step %0d: got %h expected %h", name, tag, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t t);
    in_valid    = t.in_valid;
    in_reg      = t.in_reg;
    in_data     = t.in_data;
    rf_busy     = t.rf_busy;
    lookup_reg1 = t.lk1;
    lookup_reg2 = t.lk2;
  endtask

  task automatic checkOutput(input int tag, input vec_t t);
    checkField("in_ready",     tag, 32'(in_ready),     32'(t.exp_ready));
    checkField("write_enable", tag, 32'(write_enable), 32'(t.exp_we));
    checkField("write_reg",    tag, 32'(write_reg),    32'(t.exp_wr));
    checkField("write_data",   tag, write_data,        t.exp_wd);
    checkField("count",        tag, 32'(count),        32'(t.exp_cnt));
    checkField("fwd_hit1",     tag, 32'(fwd_hit1),     32'(t.exp_hit1));
    checkField("fwd_data1",    tag, fwd_data1,         t.exp_fd1);
    checkField("fwd_hit2",     tag, 32'(fwd_hit2),     32'(t.exp_hit2));
    checkField("fwd_data2",    tag, fwd_data2,         t.exp_fd2);
  endtask

  // Drive at the falling edge, check 1 time unit later, let the rising edge act.
  task automatic runStep(input int tag, input vec_t t);
    applyStimulus(t);
    #1;
    checkOutput(tag, t);
    @(negedge clk);
  endtask

  function automatic logic [4:0] wrapReg(input int i);
    return 5'((i % 31) + 1);
  endfunction

  function automatic logic [31:0] wrapData(input int i);
    return 32'hA000_0000 + 32'(i);
  endfunction

  vec_t idle_v;

  initial begin
    idle_v = mkv(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);

    //        v  reg  data          busy lk1 lk2  rdy we wr  wd            cnt h1 d1            h2 d2
    vecs[0]  = mkv(0, 0, 32'h0,        0, 2, 3,   1, 0, 0, 32'h0,        0, 0, 32'h0,        0, 32'h0);
    vecs[1]  = mkv(1, 2, 32'hFFFFFFFF, 0, 2, 0,   1, 0, 0, 32'h0,        0, 0, 32'h0,        0, 32'h0);
    vecs[2]  = mkv(0, 0, 32'h0,        0, 2, 0,   1, 1, 2, 32'hFFFFFFFF, 1, 1, 32'hFFFFFFFF, 0, 32'h0);
    vecs[3]  = mkv(0, 0, 32'h0,        0, 2, 0,   1, 0, 0, 32'h0,        0, 0, 32'h0,        0, 32'h0);
    vecs[4]  = mkv(1, 2, 32'hFFFFFFFF, 1, 0, 0,   1, 0, 0, 32'h0,        0, 0, 32'h0,        0, 32'h0);
    vecs[5]  = mkv(1, 3, 32'h0000000A, 1, 2, 0,   1, 0, 2, 32'hFFFFFFFF, 1, 1, 32'hFFFFFFFF, 0, 32'h0);
    vecs[6]  = mkv(1, 2, 32'h00000003, 1, 2, 3,   1, 0, 2, 32'hFFFFFFFF, 2, 1, 32'hFFFFFFFF, 1, 32'h0000000A);
    vecs[7]  = mkv(0, 0, 32'h0,        1, 2, 3,   1, 0, 2, 32'hFFFFFFFF, 3, 1, 32'h00000003, 1, 32'h0000000A);
    vecs[8]  = mkv(0, 0, 32'h0,        1, 0, 5,   1, 0, 2, 32'hFFFFFFFF, 3, 0, 32'h0,        0, 32'h0);
    vecs[9]  = mkv(0, 0, 32'h0,        0, 2, 3,   1, 1, 2, 32'hFFFFFFFF, 3, 1, 32'h00000003, 1, 32'h0000000A);
    vecs[10] = mkv(0, 0, 32'h0,        0, 2, 3,   1, 1, 3, 32'h0000000A, 2, 1, 32'h00000003, 1, 32'h0000000A);
    vecs[11] = mkv(0, 0, 32'h0,        0, 2, 3,   1, 1, 2, 32'h00000003, 1, 1, 32'h00000003, 0, 32'h0);
    vecs[12] = mkv(0, 0, 32'h0,        0, 2, 3,   1, 0, 0, 32'h0,        0, 0, 32'h0,        0, 32'h0);
    vecs[13] = mkv(1, 0, 32'h12345678, 0, 0, 0,   1, 0, 0, 32'h0,        0, 0, 32'h0,        0, 32'h0);
    vecs[14] = mkv(0, 0, 32'h0,        0, 0, 0,   1, 0, 0, 32'h0,        0, 0, 32'h0,        0, 32'h0);

    rst_n = 1'b0;
    applyStimulus(idle_v);
    #1;
    checkOutput(900, idle_v);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 15; i++) runStep(i, vecs[i]);

    // Fill with the drain stalled, hold a fifth request, then drain in order.
    for (int i = 0; i < 4; i++)
      runStep(100 + i, mkv(1, 5'(i + 1), 32'h100 + 32'(i), 1, 0, 0,
                           1, 0, (i == 0) ? 5'd0 : 5'd1, (i == 0) ? 32'h0 : 32'h100,
                           3'(i), 0, 0, 0, 0));
    runStep(104, mkv(1, 5, 32'h104, 1, 0, 0, 0, 0, 1, 32'h100, 4, 0, 0, 0, 0));
    runStep(105, mkv(1, 5, 32'h104, 1, 0, 0, 0, 0, 1, 32'h100, 4, 0, 0, 0, 0));
    runStep(106, mkv(1, 5, 32'h104, 0, 0, 0, 0, 1, 1, 32'h100, 4, 0, 0, 0, 0));
    runStep(107, mkv(1, 5, 32'h104, 0, 0, 0, 1, 1, 2, 32'h101, 3, 0, 0, 0, 0));
    runStep(108, mkv(0, 0, 32'h0,   0, 0, 0, 1, 1, 3, 32'h102, 3, 0, 0, 0, 0));
    runStep(109, mkv(0, 0, 32'h0,   0, 0, 0, 1, 1, 4, 32'h103, 2, 0, 0, 0, 0));
    runStep(110, mkv(0, 0, 32'h0,   0, 0, 0, 1, 1, 5, 32'h104, 1, 0, 0, 0, 0));
    runStep(111, idle_v);

    // Back-to-back push/pop across several pointer wraps.
    runStep(200, mkv(1, wrapReg(0), wrapData(0), 0, 0, 0, 1, 0, 0, 32'h0, 0, 0, 0, 0, 0));
    for (int i = 1; i <= 10; i++)
      runStep(200 + i, mkv(1, wrapReg(i), wrapData(i), 0, 0, 0,
                           1, 1, wrapReg(i - 1), wrapData(i - 1), 1, 0, 0, 0, 0));
    runStep(211, mkv(0, 0, 0, 0, 0, 0, 1, 1, wrapReg(10), wrapData(10), 1, 0, 0, 0, 0));
    runStep(212, idle_v);

    // Reset with three entries pending.
    runStep(300, mkv(1, 7, 32'h77, 1, 0, 0, 1, 0, 0, 32'h0,  0, 0, 0, 0, 0));
    runStep(301, mkv(1, 8, 32'h88, 1, 0, 0, 1, 0, 7, 32'h77, 1, 0, 0, 0, 0));
    runStep(302, mkv(1, 9, 32'h99, 1, 0, 0, 1, 0, 7, 32'h77, 2, 0, 0, 0, 0));
    applyStimulus(mkv(0, 0, 0, 0, 7, 9, 1, 1, 7, 32'h77, 3, 1, 32'h77, 1, 32'h99));
    #1;
    checkOutput(303, mkv(0, 0, 0, 0, 7, 9, 1, 1, 7, 32'h77, 3, 1, 32'h77, 1, 32'h99));
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput(304, mkv(0, 0, 0, 0, 7, 9, 1, 0, 0, 32'h0, 0, 0, 0, 0, 0));
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput(305, mkv(0, 0, 0, 0, 7, 9, 1, 0, 0, 32'h0, 0, 0, 0, 0, 0));
    @(negedge clk);
    checkOutput(306, mkv(0, 0, 0, 0, 7, 9, 1, 0, 0, 32'h0, 0, 0, 0, 0, 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
    $finish;
  end

endmodule

// File: doc/reg_writeback_queue.md
Name: reg_writeback_queue

Overview:
- Writer-side companion to the register file.
- Buffers register write-back requests from execution units through a valid/ready input handshake.
- Drains them in order, one per cycle, onto the register file's single write port (write_reg / write_data / write_enable).
- Exposes a forwarding lookup so readers can see values still pending in the queue.

Parameters:
- DEPTH, 4, number of queue entries; power of two, minimum 2.
- ADDR_W, 5, register index width.
- DATA_W, 32, register data width.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  producer has a write request.
- in_ready  out  1  queue can accept; equals !full.
- in_reg  in  ADDR_W  destination register index.
- in_data  in  DATA_W  value to write.
- rf_busy  in  1  register file write port unavailable this cycle; holds the drain.
- write_reg  out  ADDR_W  to register file: head entry index.
- write_data  out  DATA_W  to register file: head entry data.
- write_enable  out  1  to register file: head entry valid and !rf_busy.
- lookup_reg1  in  ADDR_W  forwarding lookup index, port 1.
- lookup_reg2  in  ADDR_W  forwarding lookup index, port 2.
- fwd_hit1  out  1  lookup_reg1 matches a pending entry.
- fwd_hit2  out  1  lookup_reg2 matches a pending entry.
- fwd_data1  out  DATA_W  data of the youngest matching entry for port 1.
- fwd_data2  out  DATA_W  data of the youngest matching entry for port 2.
- count  out  $clog2(DEPTH)+1  number of occupied entries.

Behaviour:
- Reset (async assert, sync release): head, tail and count go to 0; all entry valid bits clear. All outputs read 0 except in_ready, which reads 1.
- Accept: push on a rising edge when in_valid && in_ready.
  - in_reg == 0: the request is accepted (handshake completes) but dropped; count is unchanged.
- Drain: write_reg, write_data and write_enable are combinational from the head entry.
  - write_enable = (count != 0) && !rf_busy.
  - Pop on the rising edge where write_enable is high, so the register file commits on that same edge.
- Latency: a request accepted at edge N drives the write port during cycle N..N+1 and commits at edge N+1, provided rf_busy is low and it is at the head.
- Ordering: strict FIFO, with no coalescing of writes to the same register.
- Full: in_ready is low when count == DEPTH, even if a pop occurs the same cycle. There is no same-cycle pass-through.
- Empty: write_enable is low; write_reg and write_data read 0.
- Simultaneous push and pop (not full, not empty): count is unchanged and both pointers advance.
- Pointer wrap: pointers are log2(DEPTH) bits and wrap modulo DEPTH. Full and empty are decided by count alone.
- Forwarding: combinational comparison of lookup_regN against all valid entries; the youngest match (closest to tail) wins.
  - lookup_regN == 0 never hits, and fwd_dataN reads 0 on a miss.
  - The entry being popped this cycle still hits. The entry being pushed this cycle does not hit until the next cycle.
- rf_busy held high: the queue fills and in_ready drops. Forwarding stays correct throughout.
- Reset mid-operation: all pending writes are discarded, with no partial write. write_enable falls immediately on assertion.

Optional Feature:
- Macro RWQ_FORWARD_EN.
- Defined: forwarding logic is built as described above.
- Undefined: the fwd_hit*/fwd_data* ports remain, tied to 0, and the lookup inputs are ignored. Queue behaviour is otherwise identical.

Decomposition:
- Package rwq_pkg:
  - ADDR_W and DATA_W default constants.
  - typedef rwq_entry_t {valid, reg index, data}.
- One sub-module, rwq_fwd_match:
  - Parameterised youngest-match priority search over the entry array, taking the tail pointer.
  - Instantiated twice, once per lookup port.

Test Plan:
- Reset, then push (reg 2, FFFFFFFF) at edge 1 -> at edge 2: write_enable=1, write_reg=2, write_data=FFFFFFFF; count returns to 0 after edge 2.
- Push reg 2=FFFFFFFF, then reg 3=0000000A, then reg 2=00000003 on consecutive cycles with rf_busy=1 -> count=3. lookup_reg1=2 gives fwd_hit1=1, fwd_data1=00000003 (youngest). lookup_reg2=3 gives 0000000A.
- Push reg 0=12345678 -> in_ready stays 1, count stays 0, write_enable never asserts.
- rf_busy=1, push DEPTH+1 requests -> in_ready=0 after the 4th push and the 5th is held. Release rf_busy -> 4 writes in FIFO order on consecutive cycles, then the 5th.
- Continuous push/pop for 10 cycles with incrementing data (pointer wrap) -> the write port sequence matches the input sequence exactly, with count constant at 1.
- Assert rst_n=0 with 3 pending entries -> write_enable=0 immediately. After release: count=0, fwd_hit1=fwd_hit2=0, in_ready=1.
